key_click_detect: RTL and testbench
===================================

Name: key_click_detect

Overview:
- Sits directly downstream of the key debouncer.
- Consumes the debouncer's single-cycle press pulse and classifies each press burst as a single, double or triple click, using a configurable inter-click window.
- Emits one registered single-cycle pulse per classified burst to the mode/LED control logic.
- Pure pulse-domain logic: it sees no raw key levels and does no debouncing.

Parameters:
- WINDOW, 10, max clocks allowed between consecutive clicks of one burst (synthesis top overrides to 25_000_000 for 0.5 s at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 26, width of window counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous assert, active-low
- key_pulse  input  1  debounced press pulse; each cycle sampled high counts as one click
- single_click  output  1  one-cycle pulse: burst of exactly 1 click ended
- double_click  output  1  one-cycle pulse: burst of exactly 2 clicks ended
- triple_click  output  1  one-cycle pulse: third click of a burst seen
- busy  output  1  high while a burst is open (state != IDLE); decoded from state register

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, cnt=0, single/double/triple_click=0, busy=0. Reset mid-burst discards the burst with no output pulse. Deassertion is assumed synchronised externally.
- One-hot states: IDLE=3'b001, ONE=3'b010, TWO=3'b100. Any illegal encoding returns to IDLE next edge with all outputs 0.
- Notation: E0 is the edge that samples the first key_pulse=1; Ek is the k-th edge after E0.
- IDLE:
  - key_pulse=1 -> ONE, cnt<=0.
  - Otherwise stay in IDLE, cnt<=0.
- ONE:
  - key_pulse=1 -> TWO, cnt<=0.
  - Else if cnt==WINDOW-1 -> IDLE, single_click<=1.
  - Else cnt<=cnt+1.
- TWO:
  - key_pulse=1 -> IDLE, triple_click<=1, cnt<=0.
  - Else if cnt==WINDOW-1 -> IDLE, double_click<=1.
  - Else cnt<=cnt+1.
- Timing:
  - After a click at E0, a following click sampled at any edge E1..E_WINDOW (inclusive) joins the burst.
  - With no further click, single_click is high for exactly the cycle after E_WINDOW.
  - Latency from the last click to the single or double pulse is therefore WINDOW+1 edges.
  - triple_click rises on the edge that samples the third click (1-edge latency).
- Simultaneous events:
  - key_pulse=1 on the same edge as timeout: the click wins; the timer restarts and no single/double pulse is emitted.
  - key_pulse=1 in IDLE on the same cycle an output pulse is high: accepted as the first click of a new burst.
- Back-to-back key_pulse highs count as separate clicks; there is no internal edge detection.
- Clicks beyond three: the 4th click starts a new burst.
- Outputs are mutually exclusive and each lasts exactly one cycle. All outputs not pulsed are 0.
- Counter width: cnt never exceeds WINDOW-1, so no wrap. Comparison is done at CNT_W bits.

Decomposition:
- Shared package key_pkg:
  - state localparams KC_IDLE, KC_ONE, KC_TWO (one-hot, 3 bits);
  - default WINDOW / CNT_W constants, reused by the debouncer's delay parameter.
- Optional sub-module click_window_timer:
  - inputs clear and run;
  - outputs cnt and expired (cnt==WINDOW-1);
  - FSM drives clear on every click and in IDLE.
- A single flat module is also acceptable.

Test Plan:
- Reset mid-burst: WINDOW=10; pulse at E0, rst_n low for 3 cycles at E4 -> all outputs stay 0, busy=0 immediately on reset assertion, no pulse after release.
- Single click: one pulse at E0 -> busy=1 from E0 to E10; single_click=1 only in the cycle after E10; busy=0 after E10.
- Double click: pulses at E0 and E5 -> double_click=1 only in the cycle after E15; single_click never asserted.
- Triple click: pulses at E0, E3, E6 -> triple_click=1 in the cycle after E6; busy=0; no single/double pulse follows within 20 cycles.
- Window boundary:
  - pulses at E0 and E10 -> counted as a double; double_click after E20.
  - pulses at E0 and E11 -> single_click after E10, then a new burst giving single_click after E21.
- Back-to-back and overlap:
  - key_pulse high for 2 consecutive cycles -> treated as double; double_click WINDOW+1 edges after the second.
  - pulse in the same cycle single_click is high -> new burst opens; single_click again 11 edges later.

Source files
------------

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared key-path constants and click FSM state encoding
package key_pkg;

   localparam int KC_DEF_WINDOW = 10;
   localparam int KC_DEF_CNT_W  = 26;

   typedef enum logic [2:0] {
      KC_IDLE = 3'b001,
      KC_ONE  = 3'b010,
      KC_TWO  = 3'b100
   } kc_state_t;

endpackage

// File: rtl/click_window_timer.sv
// rtl/click_window_timer.sv - inter-click window counter with expiry flag
module click_window_timer
   import key_pkg::*;
#(
   parameter int WINDOW = KC_DEF_WINDOW,
   parameter int CNT_W  = KC_DEF_CNT_W
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WINDOW - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (run) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign expired = (r_cnt == LP_LAST);

endmodule

// File: rtl/key_click_detect.sv
// rtl/key_click_detect.sv - classifies debounced press bursts into single/double/triple clicks
module key_click_detect
   import key_pkg::*;
#(
   parameter int WINDOW = KC_DEF_WINDOW,
   parameter int CNT_W  = KC_DEF_CNT_W
)(
   input  logic clk,
   input  logic rst_n,
   input  logic key_pulse,
   output logic single_click,
   output logic double_click,
   output logic triple_click,
   output logic busy
);

   kc_state_t r_state;
   kc_state_t w_state_nxt;
   logic      r_single, r_double, r_triple;
   logic      w_single_nxt, w_double_nxt, w_triple_nxt;
   logic      w_clear, w_run, w_expired;

   click_window_timer #(
      .WINDOW (WINDOW),
      .CNT_W  (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_clear),
      .run     (w_run),
      .expired (w_expired)
   );

   // A click always wins over a simultaneous window expiry.
   always_comb begin
      w_state_nxt  = KC_IDLE;
      w_single_nxt = 1'b0;
      w_double_nxt = 1'b0;
      w_triple_nxt = 1'b0;
      w_clear      = 1'b1;
      w_run        = 1'b0;
      case (r_state)
         KC_IDLE: begin
            if (key_pulse) w_state_nxt = KC_ONE;
         end
         KC_ONE: begin
            if (key_pulse) begin
               w_state_nxt = KC_TWO;
            end else if (w_expired) begin
               w_single_nxt = 1'b1;
            end else begin
               w_state_nxt = KC_ONE;
               w_clear     = 1'b0;
               w_run       = 1'b1;
            end
         end
         KC_TWO: begin
            if (key_pulse) begin
               w_triple_nxt = 1'b1;
            end else if (w_expired) begin
               w_double_nxt = 1'b1;
            end else begin
               w_state_nxt = KC_TWO;
               w_clear     = 1'b0;
               w_run       = 1'b1;
            end
         end
         default: begin
            w_state_nxt = KC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= KC_IDLE;
         r_single <= 1'b0;
         r_double <= 1'b0;
         r_triple <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_single <= w_single_nxt;
         r_double <= w_double_nxt;
         r_triple <= w_triple_nxt;
      end
   end

   assign single_click = r_single;
   assign double_click = r_double;
   assign triple_click = r_triple;
   assign busy         = (r_state == KC_ONE) || (r_state == KC_TWO);

endmodule

// File: tb/tb_key_click_detect.sv
// tb/tb_key_click_detect.sv - self-checking bench for key_click_detect against a burst-timing model
module tb_key_click_detect;

   localparam int WINDOW = 10;

   logic clk;
   logic rst_n;
   logic key_pulse;
   logic single_click, double_click, triple_click, busy;

   int checks;
   int errors;

   // Model: clicks in the open burst and edge index of its most recent click.
   int n_clicks;
   int last_edge;
   int edge_no;
   logic exp_single, exp_double, exp_triple;

   key_click_detect #(.WINDOW(WINDOW), .CNT_W(26)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_pulse    (key_pulse),
      .single_click (single_click),
      .double_click (double_click),
      .triple_click (triple_click),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag);
      logic [3:0] obs, exp;
      obs = {single_click, double_click, triple_click, busy};
      exp = {exp_single, exp_double, exp_triple, (n_clicks > 0)};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d observed(s,d,t,busy)=%b expected=%b", tag, edge_no, obs, exp);
      end
   endtask

   task automatic model_edge(input logic p);
      exp_single = 1'b0;
      exp_double = 1'b0;
      exp_triple = 1'b0;
      if (!rst_n) begin
         n_clicks = 0;
      end else if (n_clicks == 0) begin
         if (p) begin
            n_clicks  = 1;
            last_edge = edge_no;
         end
      end else if (p && (edge_no - last_edge) <= WINDOW) begin
         n_clicks++;
         last_edge = edge_no;
         if (n_clicks == 3) begin
            exp_triple = 1'b1;
            n_clicks   = 0;
         end
      end else if ((edge_no - last_edge) == WINDOW) begin
         exp_single = (n_clicks == 1);
         exp_double = (n_clicks == 2);
         n_clicks   = 0;
      end
   endtask

   task automatic step(input logic p, input string tag);
      key_pulse = p;
      @(posedge clk);
      edge_no++;
      model_edge(p);
      #1;
      chk(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, tag);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      n_clicks  = 0;
      last_edge = 0;
      edge_no   = 0;
      exp_single = 1'b0;
      exp_double = 1'b0;
      exp_triple = 1'b0;
      key_pulse = 1'b0;
      rst_n     = 1'b0;

      idle(3, "reset");
      rst_n = 1'b1;
      idle(2, "post_reset");

      // Single click
      step(1'b1, "single");
      idle(14, "single");

      // Double click E0, E5
      step(1'b1, "double");
      idle(4, "double");
      step(1'b1, "double");
      idle(14, "double");

      // Triple click E0, E3, E6, then quiet
      step(1'b1, "triple");
      idle(2, "triple");
      step(1'b1, "triple");
      idle(2, "triple");
      step(1'b1, "triple");
      idle(20, "triple_quiet");

      // Window boundary: E0/E10 joins, E0/E11 splits
      step(1'b1, "win_edge_in");
      idle(9, "win_edge_in");
      step(1'b1, "win_edge_in");
      idle(14, "win_edge_in");
      step(1'b1, "win_edge_out");
      idle(10, "win_edge_out");
      step(1'b1, "win_edge_out");
      idle(14, "win_edge_out");

      // Back-to-back pulses
      step(1'b1, "b2b");
      step(1'b1, "b2b");
      idle(14, "b2b");

      // New burst in the cycle single_click is high
      step(1'b1, "overlap");
      idle(10, "overlap");
      step(1'b1, "overlap");
      idle(14, "overlap");

      // Four quick clicks: triple then a fresh burst
      for (int i = 0; i < 4; i++) step(1'b1, "four");
      idle(14, "four");

      // Reset mid-burst
      step(1'b1, "rst_mid");
      idle(3, "rst_mid");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_clicks = 0;
      exp_single = 1'b0;
      exp_double = 1'b0;
      exp_triple = 1'b0;
      chk("rst_async");
      idle(3, "rst_hold");
      rst_n = 1'b1;
      idle(15, "rst_after");

      // Randomised traffic with varying click density
      for (int i = 0; i < 600; i++) begin
         int dens;
         dens = (i / 150) + 2;
         step(($urandom_range(0, dens) == 0), "random");
      end
      idle(15, "drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
